mvu_pe_gen: RTL and testbench



---
 rtl/mvu_pe_gen_pkg.sv | 20 ++
 rtl/mvu_pe_gen_lane.sv | 30 +++
 rtl/mvu_pe_gen.sv | 152 +++++++++++++++
 tb/tb_mvu_pe_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mvu_pe_gen_pkg.sv
// Shared types and helpers for the mvu_pe_gen processing element.
// Optional build macro MVU_PE_GEN_SAT_EN (see mvu_pe_gen.sv) uses the bounds below.
package mvu_pe_gen_pkg;

    typedef enum logic [1:0] {
        STD     = 2'd0,
        XNOR    = 2'd1,
        BIN_ACT = 2'd2,
        BIN_WGT = 2'd3
    } mvu_mode_t;

    function automatic longint sat_hi(input int unsigned w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int unsigned w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/mvu_pe_gen_lane.sv
// Combinational single-lane product for the four MVU arithmetic modes.
module mvu_pe_gen_lane
    import mvu_pe_gen_pkg::*;
#(
    parameter int unsigned TSRCI = 4,
    parameter int unsigned TW    = 4,
    parameter int unsigned PW    = TSRCI + TW
) (
    input  logic [TSRCI-1:0]     act,
    input  logic [TW-1:0]        wgt,
    input  mvu_mode_t            mode,
    output logic signed [PW-1:0] prod
);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] w_ext;

    always_comb begin
        a_ext = PW'($signed(act));
        w_ext = PW'($signed(wgt));
        prod  = '0;
        unique case (mode)
            STD:     prod = a_ext * w_ext;
            XNOR:    prod = PW'(act[0] == wgt[0]);
            BIN_ACT: prod = act[0] ? w_ext : -w_ext;
            BIN_WGT: prod = wgt[0] ? a_ext : -a_ext;
        endcase
    end

endmodule

// File: rtl/mvu_pe_gen.sv
// MVU processing element: SIMD lane products, registered adder tree, SF-beat accumulation.
// Build macro MVU_PE_GEN_SAT_EN: saturate the output narrowing instead of truncating.
module mvu_pe_gen
    import mvu_pe_gen_pkg::*;
#(
    parameter int unsigned SIMD  = 4,
    parameter int unsigned TSRCI = 4,
    parameter int unsigned TW    = 4,
    parameter int unsigned TDSTI = 16,
    parameter int unsigned SF    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_v,
    output logic                    in_rdy,
    input  logic [SIMD*TSRCI-1:0]   in_act,
    input  logic [SIMD*TW-1:0]      in_wgt,
    input  logic [1:0]              mode,
    output logic                    out_v,
    input  logic                    out_rdy,
    output logic [TDSTI-1:0]        out
);

    localparam int unsigned PW = TSRCI + TW;
    localparam int unsigned SW = PW + $clog2(SIMD);
    localparam int unsigned AW = PW + $clog2(SIMD) + $clog2(SF) + 1;
    localparam int unsigned CW = (SF > 1) ? $clog2(SF) : 1;
    localparam int unsigned WW = (AW > TDSTI) ? AW : TDSTI;

    logic stall, adv, accept;
    logic [CW-1:0] cnt_q;
    mvu_mode_t     mode_q, beat_mode;
    logic          beat_first, beat_last;

    logic                      s1_v, s1_first, s1_last;
    logic [SIMD*TSRCI-1:0]     s1_act;
    logic [SIMD*TW-1:0]        s1_wgt;
    mvu_mode_t                 s1_mode;
    logic signed [PW-1:0]      lane_prod [SIMD];

    logic                      s2_v, s2_first, s2_last;
    logic signed [PW-1:0]      s2_prod [SIMD];
    logic signed [SW-1:0]      tree_sum;

    logic                      s3_v, s3_first, s3_last;
    logic signed [SW-1:0]      s3_sum;
    logic signed [AW-1:0]      s3_ext, acc_q, res;
    logic signed [WW-1:0]      wide;
    logic [TDSTI-1:0]          narrowed;

    assign stall  = out_v && !out_rdy;
    assign in_rdy = !stall;
    assign adv    = !stall;
    assign accept = in_v && in_rdy;

    assign beat_first = (cnt_q == '0);
    assign beat_last  = (cnt_q == CW'(SF - 1));
    // Beat 0 takes the live mode; later beats reuse the latched group mode.
    assign beat_mode  = beat_first ? mvu_mode_t'(mode) : mode_q;

    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        mvu_pe_gen_lane #(
            .TSRCI (TSRCI),
            .TW    (TW),
            .PW    (PW)
        ) u_lane (
            .act  (s1_act[i*TSRCI +: TSRCI]),
            .wgt  (s1_wgt[i*TW +: TW]),
            .mode (s1_mode),
            .prod (lane_prod[i])
        );
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            tree_sum = tree_sum + SW'(s2_prod[i]);
        end
    end

    assign s3_ext = AW'(s3_sum);
    assign res    = s3_first ? s3_ext : acc_q + s3_ext;

`ifdef MVU_PE_GEN_SAT_EN
    localparam logic signed [WW-1:0] SAT_HI = WW'(sat_hi(TDSTI));
    localparam logic signed [WW-1:0] SAT_LO = WW'(sat_lo(TDSTI));

    always_comb begin
        wide     = WW'(res);
        narrowed = wide[TDSTI-1:0];
        if (wide > SAT_HI) begin
            narrowed = SAT_HI[TDSTI-1:0];
        end else if (wide < SAT_LO) begin
            narrowed = SAT_LO[TDSTI-1:0];
        end
    end
`else
    always_comb begin
        wide     = WW'(res);
        narrowed = wide[TDSTI-1:0];
    end
`endif

    // Control state: valids, beat counter, accumulator and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mode_q <= STD;
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s3_v   <= 1'b0;
            acc_q  <= '0;
            out_v  <= 1'b0;
            out    <= '0;
        end else if (adv) begin
            if (accept) begin
                cnt_q <= beat_last ? '0 : cnt_q + CW'(1);
                if (beat_first) begin
                    mode_q <= mvu_mode_t'(mode);
                end
            end
            s1_v <= accept;
            s2_v <= s1_v;
            s3_v <= s2_v;
            if (s3_v) begin
                acc_q <= res;
            end
            out_v <= s3_v && s3_last;
            if (s3_v && s3_last) begin
                out <= narrowed;
            end
        end
    end

    // Datapath registers; qualified by the valids above, so no reset needed.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_act   <= in_act;
            s1_wgt   <= in_wgt;
            s1_mode  <= beat_mode;
            s1_first <= beat_first;
            s1_last  <= beat_last;
            s2_prod  <= lane_prod;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s3_sum   <= tree_sum;
            s3_first <= s2_first;
            s3_last  <= s2_last;
        end
    end

endmodule

// File: tb/tb_mvu_pe_gen.sv
// Self-checking bench for mvu_pe_gen: directed groups, backpressure, reset, random traffic.
module tb_mvu_pe_gen;

    localparam int SIMD  = 4;
    localparam int TSRCI = 4;
    localparam int TW    = 4;
    localparam int SF    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_v, out_rdy;
    logic [1:0]  mode;
    logic [15:0] in_act, in_wgt;
    logic        in_rdy, out_v, in_rdy8, out_v8;
    logic [15:0] out;
    logic [7:0]  out8;

    always #5 clk = ~clk;

    mvu_pe_gen #(
        .SIMD(SIMD), .TSRCI(TSRCI), .TW(TW), .TDSTI(16), .SF(SF)
    ) dut (
        .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy), .in_act(in_act),
        .in_wgt(in_wgt), .mode(mode), .out_v(out_v), .out_rdy(out_rdy), .out(out)
    );

    mvu_pe_gen #(
        .SIMD(SIMD), .TSRCI(TSRCI), .TW(TW), .TDSTI(8), .SF(SF)
    ) dut8 (
        .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy8), .in_act(in_act),
        .in_wgt(in_wgt), .mode(mode), .out_v(out_v8), .out_rdy(out_rdy), .out(out8)
    );

    int nvec = 0;
    int nerr = 0;
    int exp_q[$];
    int exp8_q[$];
    int mb = 0;
    int mmode = 0;
    int gsum = 0;
    int hs_cnt = 0;
    int hs_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int narrow(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
`ifdef MVU_PE_GEN_SAT_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
`endif
        return v;
    endfunction

    function automatic int lane_ref(input int a, input int w, input int m);
        case (m)
            0:       return a * w;
            1:       return ((a & 1) == (w & 1)) ? 1 : 0;
            2:       return (a & 1) ? w : -w;
            default: return (w & 1) ? a : -a;
        endcase
    endfunction

    // Reference: signed lane values summed per beat, SF beats per result.
    task automatic model_beat();
        int a, w;
        if (mb == 0) begin
            mmode = int'(mode);
            gsum  = 0;
        end
        for (int i = 0; i < SIMD; i++) begin
            a = $signed(in_act[i*TSRCI +: TSRCI]);
            w = $signed(in_wgt[i*TW +: TW]);
            gsum += lane_ref(a, w, mmode);
        end
        mb++;
        if (mb == SF) begin
            exp_q.push_back(gsum);
            exp8_q.push_back(gsum);
            mb = 0;
        end
    endtask

    // One clock: drive at negedge, check just after, then cross the posedge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] w,
                         input logic [1:0] m, input logic r, input int eov);
        in_v = v; in_act = a; in_wgt = w; mode = m; out_rdy = r;
        #1;
        if (eov >= 0) chk("out_v", {31'd0, out_v}, eov);
        chk("in_rdy", {31'd0, in_rdy}, {31'd0, !(out_v && !out_rdy)});
        chk("in_rdy8", {31'd0, in_rdy8}, {31'd0, !(out_v8 && !out_rdy)});
        if (out_v && out_rdy) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("spurious_out_v", {31'd0, out_v}, 32'd0);
            else chk("out", {16'd0, out}, {16'd0, 16'(narrow(exp_q.pop_front(), 16))});
        end
        if (out_v8 && out_rdy) begin
            if (exp8_q.size() == 0) chk("spurious_out_v8", {31'd0, out_v8}, 32'd0);
            else chk("out8", {24'd0, out8}, {24'd0, 8'(narrow(exp8_q.pop_front(), 8))});
        end
        if (rst) mb = 0;
        else if (in_v && in_rdy) model_beat();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_v = 1'b0; in_act = '0; in_wgt = '0; mode = 2'd0; out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_v", {31'd0, out_v}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_out8", {24'd0, out8}, 32'd0);
        rst = 1'b0;

        // STD: 2*3 per lane, 4 lanes, 3 beats = 72; out_v exactly on the 4th cycle after.
        for (int k = 0; k < 3; k++) cycle(1'b1, 16'h2222, 16'h3333, 2'd0, 1'b1, 0);
        for (int j = 1; j <= 6; j++) cycle(1'b0, '0, '0, 2'd0, 1'b1, (j == 4) ? 1 : 0);
        chk("std_72", {16'd0, out}, 32'h0048);

        // XNOR: lanes match on 0 and 3 -> 2 per beat; STD on beat 2 must be ignored.
        cycle(1'b1, 16'h0101, 16'h0011, 2'd1, 1'b1, -1);
        cycle(1'b1, 16'h0101, 16'h0011, 2'd1, 1'b1, -1);
        cycle(1'b1, 16'h0101, 16'h0011, 2'd0, 1'b1, -1);
        for (int j = 1; j <= 6; j++) cycle(1'b0, '0, '0, 2'd0, 1'b1, (j == 4) ? 1 : 0);
        chk("xnor_6", {16'd0, out}, 32'd6);

        // BIN_ACT with act[0]=0: -5 per lane -> -60.
        for (int k = 0; k < 3; k++) cycle(1'b1, 16'h0000, 16'h5555, 2'd2, 1'b1, -1);
        for (int j = 1; j <= 6; j++) cycle(1'b0, '0, '0, 2'd0, 1'b1, (j == 4) ? 1 : 0);
        chk("binact_m60", {16'd0, out}, 32'h0000FFC4);

        // Backpressure: two STD groups, out_rdy low for 5 cycles once the first result shows.
        hs_base = hs_cnt;
        for (int k = 0; k < 6; k++) cycle(1'b1, 16'h2222, 16'h3333, 2'd0, 1'b1, -1);
        for (int j = 0; j < 5; j++) begin
            cycle(1'b0, '0, '0, 2'd0, 1'b0, 1);
            chk("bp_hold", {16'd0, out}, 32'd72);
            chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
        end
        cycle(1'b0, '0, '0, 2'd0, 1'b1, 1);
        cycle(1'b0, '0, '0, 2'd0, 1'b1, 0);
        cycle(1'b0, '0, '0, 2'd0, 1'b1, 0);
        cycle(1'b0, '0, '0, 2'd0, 1'b1, 1);
        for (int j = 0; j < 3; j++) cycle(1'b0, '0, '0, 2'd0, 1'b1, 0);
        chk("bp_second", {16'd0, out}, 32'd72);
        chk("bp_count", hs_cnt - hs_base, 32'd2);

        // 49*4*3 = 588: saturates to 127 or wraps to 76 in the 8-bit instance.
        for (int k = 0; k < 3; k++) cycle(1'b1, 16'h7777, 16'h7777, 2'd0, 1'b1, -1);
        for (int j = 1; j <= 6; j++) cycle(1'b0, '0, '0, 2'd0, 1'b1, (j == 4) ? 1 : 0);
        chk("w16_588", {16'd0, out}, 32'd588);
`ifdef MVU_PE_GEN_SAT_EN
        chk("w8_sat", {24'd0, out8}, 32'd127);
`else
        chk("w8_wrap", {24'd0, out8}, 32'd76);
`endif

        // Reset mid-group: partial sum of two beats must be discarded.
        cycle(1'b1, 16'h3333, 16'h3333, 2'd0, 1'b1, -1);
        cycle(1'b1, 16'h3333, 16'h3333, 2'd0, 1'b1, -1);
        rst = 1'b1;
        cycle(1'b0, '0, '0, 2'd0, 1'b1, 0);
        cycle(1'b0, '0, '0, 2'd0, 1'b1, 0);
        rst = 1'b0;
        cycle(1'b0, '0, '0, 2'd0, 1'b1, 0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 16'h1111, 16'h1111, 2'd0, 1'b1, 0);
        for (int j = 1; j <= 6; j++) cycle(1'b0, '0, '0, 2'd0, 1'b1, (j == 4) ? 1 : 0);
        chk("rst_12", {16'd0, out}, 32'd12);

        // Random traffic: bubbles, backpressure, mode changes mid-group.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, -1);
        end
        for (int k = 0; k < 60 && (exp_q.size() > 0 || exp8_q.size() > 0); k++) begin
            cycle(1'b0, '0, '0, 2'd0, 1'b1, -1);
        end
        chk("drain16", exp_q.size(), 32'd0);
        chk("drain8", exp8_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
